// File: rtl/fsm_serial_pkg.sv
// Shared types and constants for the serial transmitter slice.
// Latency: none (declarations only).
// Backpressure: not applicable.
//
// Contents: tx_state_t frame-sequencer states, parity mode codes,
// DATA_BITS, and a parity helper shared by RTL and anything that needs
// to predict the parity bit.
package fsm_serial_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } tx_state_t;

  localparam int PAR_NONE  = 0;
  localparam int PAR_EVEN  = 1;
  localparam int PAR_ODD   = 2;

  localparam int DATA_BITS = 8;

  // Even mode: XOR of the data bits. Odd mode: its inverse.
  // The result is meaningless for PAR_NONE and is never transmitted then.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] d,
                                      input int                   mode);
    logic x;
    x = ^d;
    return (mode == PAR_ODD) ? ~x : x;
  endfunction

endpackage

// File: rtl/fsm_serial_tx_if.sv
// Byte-input handshake bundle for the serial transmitter.
// Latency: none (wires only).
// Backpressure: producer holds in_data/in_valid until in_ready is seen high.
//
// Signals:
//   in_data  - byte offered by the producer
//   in_valid - in_data is valid
//   in_ready - transmitter accepts the byte on this cycle's rising edge
// Modports: master = byte producer, slave = transmitter.
interface fsm_serial_tx_if;
  import fsm_serial_pkg::*;

  logic [DATA_BITS-1:0] in_data;
  logic                 in_valid;
  logic                 in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );

endinterface

// File: rtl/fsm_serial_tx_baud_tick.sv
// Bit-period timer: one-cycle tick on the last clock of every bit period.
// Latency: tick is combinational from the count; first tick CLKS_PER_BIT-1 cycles after clear.
// Backpressure: none; counts only while enable is high, clear wins over enable.
//
// Ports:
//   clk, reset_n - clock, asynchronous active-low reset
//   clear        - restart the bit period at count 0 on the next edge
//   enable       - advance the count (transmitter is mid-frame)
//   tick         - high during the final cycle of a bit period
module serial_baud_tick #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 1) begin : g_bad_cpb
    $error("serial_baud_tick: CLKS_PER_BIT must be at least 1");
  end

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  // With CLKS_PER_BIT=1 the count is pinned at 0 and every enabled cycle ticks.
  assign tick = enable && (cnt == LAST);

endmodule

// File: rtl/fsm_serial_tx.sv
// Serial byte transmitter: start bit, 8 data bits LSB-first, optional parity, 1-2 stop bits.
// Latency: byte accepted in cycle N drives the start bit from cycle N+1 (dout is a flop).
// Backpressure: in_ready only in IDLE or the final stop cycle; in_valid ignored otherwise.
//
// Ports:
//   clk, reset_n - clock, asynchronous active-low reset (dout forced to 1)
//   in_if        - byte handshake (slave side: in_data, in_valid, in_ready)
//   dout         - registered serial line, idle high
//   busy         - frame in progress (any state but IDLE)
//   done         - one-cycle pulse in the last cycle of the last stop bit
module fsm_serial_tx
  import fsm_serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1,
  parameter int PARITY       = PAR_NONE,
  parameter int STOP_BITS    = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  fsm_serial_tx_if.slave  in_if,
  output logic            dout,
  output logic            busy,
  output logic            done
);

  localparam int BCW = $clog2(DATA_BITS);
  localparam logic [BCW-1:0] LAST_BIT  = BCW'(DATA_BITS - 1);
  localparam logic           LAST_STOP = 1'(STOP_BITS - 1);

  if (PARITY != PAR_NONE && PARITY != PAR_EVEN && PARITY != PAR_ODD) begin : g_bad_par
    $error("fsm_serial_tx: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("fsm_serial_tx: STOP_BITS must be 1 or 2");
  end

  tx_state_t            state, state_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic [BCW-1:0]       bit_cnt, bit_cnt_nxt;
  logic                 stop_cnt, stop_cnt_nxt;
  logic                 par_bit, par_nxt;
  logic                 dout_nxt;

  logic                 tick;
  logic                 ready;
  logic                 last_stop;
  logic                 accept;

  serial_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (accept),
    .enable  (state != IDLE),
    .tick    (tick)
  );

  assign in_if.in_ready = ready;
  assign accept         = in_if.in_valid && ready;

  // State register. dout is registered from the next-state decode so the
  // line changes on the same edge the FSM enters the matching state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      par_bit  <= 1'b0;
      dout     <= 1'b1;
    end else begin
      state    <= state_nxt;
      shreg    <= shreg_nxt;
      bit_cnt  <= bit_cnt_nxt;
      stop_cnt <= stop_cnt_nxt;
      par_bit  <= par_nxt;
      dout     <= dout_nxt;
    end
  end

  // Next-state logic. An accept can only happen in IDLE or the last stop
  // cycle, and in both cases it starts a fresh frame, so it is handled
  // ahead of the per-state transitions.
  always_comb begin
    state_nxt    = state;
    shreg_nxt    = shreg;
    bit_cnt_nxt  = bit_cnt;
    stop_cnt_nxt = stop_cnt;
    par_nxt      = par_bit;

    if (accept) begin
      state_nxt    = START;
      shreg_nxt    = in_if.in_data;
      bit_cnt_nxt  = '0;
      stop_cnt_nxt = 1'b0;
      par_nxt      = parity_bit(in_if.in_data, PARITY);
    end else if (tick) begin
      case (state)
        START: state_nxt = DATA;
        DATA: begin
          if (bit_cnt == LAST_BIT) begin
            state_nxt = (PARITY != PAR_NONE) ? PAR : STOP;
          end else begin
            bit_cnt_nxt = bit_cnt + 1'b1;
            shreg_nxt   = shreg >> 1;
          end
        end
        PAR:  state_nxt = STOP;
        STOP: begin
          if (stop_cnt == LAST_STOP) begin
            state_nxt = IDLE;
          end else begin
            stop_cnt_nxt = stop_cnt + 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    // Line value for the state being entered. In DATA the current bit is
    // always the shift register LSB, already shifted on a bit advance.
    case (state_nxt)
      START:   dout_nxt = 1'b0;
      DATA:    dout_nxt = shreg_nxt[0];
      PAR:     dout_nxt = par_nxt;
      default: dout_nxt = 1'b1;
    endcase
  end

  // Outputs. Opening in_ready during the final stop cycle lets the next
  // start bit follow the stop bit with no idle gap.
  always_comb begin
    last_stop = (state == STOP) && tick && (stop_cnt == LAST_STOP);
    busy      = (state != IDLE);
    done      = last_stop;
    ready     = (state == IDLE) || last_stop;
  end

endmodule

// File: tb/tb_fsm_serial_tx.sv
// Bench for fsm_serial_tx: three instances (defaults; even parity at 4 clocks/bit;
// odd parity with two stop bits). The driver pushes the hand-written expected frame
// on every accept; a monitor decodes each dout frame and checks it against the queue.
module tb_fsm_serial_tx;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  fsm_serial_tx_if if_a ();
  fsm_serial_tx_if if_b ();
  fsm_serial_tx_if if_c ();

  wire [2:0] dout_v;
  wire [2:0] busy_v;
  wire [2:0] done_v;

  fsm_serial_tx #(.CLKS_PER_BIT(1), .PARITY(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .in_if(if_a),
    .dout(dout_v[0]), .busy(busy_v[0]), .done(done_v[0]));

  fsm_serial_tx #(.CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .in_if(if_b),
    .dout(dout_v[1]), .busy(busy_v[1]), .done(done_v[1]));

  fsm_serial_tx #(.CLKS_PER_BIT(1), .PARITY(2), .STOP_BITS(2)) dut_c (
    .clk(clk), .reset_n(reset_n), .in_if(if_c),
    .dout(dout_v[2]), .busy(busy_v[2]), .done(done_v[2]));

  // Frame bits LSB-first: bit 0 is the start bit; unused top bits are padding.
  typedef struct {
    int          inst;
    logic [11:0] bits;
    int          acc_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   frames_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic set_in(input int inst, input logic v, input logic [7:0] d);
    case (inst)
      0: begin if_a.in_valid = v; if_a.in_data = d; end
      1: begin if_b.in_valid = v; if_b.in_data = d; end
      default: begin if_c.in_valid = v; if_c.in_data = d; end
    endcase
  endtask

  function automatic logic get_ready(input int inst);
    case (inst)
      0: return if_a.in_ready;
      1: return if_b.in_ready;
      default: return if_c.in_ready;
    endcase
  endfunction

  // Offer a byte and wait (bounded) for the accept; hold keeps in_valid high
  // afterwards so a following send can go back-to-back.
  task automatic send(input int inst, input logic [7:0] d, input logic [11:0] frame,
                      input bit hold);
    bit ok;
    exp_t e;
    ok = 1'b0;
    @(negedge clk);
    set_in(inst, 1'b1, d);
    for (int i = 0; i < 200 && !ok; i++) begin
      if (get_ready(inst) === 1'b1) begin
        ok = 1'b1;
        e.inst = inst; e.bits = frame; e.acc_cyc = cyc;
        exp_q.push_back(e);
      end else begin
        @(negedge clk);
      end
    end
    check($sformatf("accepted[%0d]", inst), {31'd0, ok}, 1);
    @(posedge clk);
    #1;
    if (!hold) set_in(inst, 1'b0, 8'h00);
  endtask

  // Monitor: per instance, a low line while idle opens a frame.
  int   cpb[3]   = '{1, 4, 1};
  int   nbits[3] = '{10, 11, 12};
  bit   in_frame[3] = '{default: 1'b0};
  bit   have[3]     = '{default: 1'b0};
  int   fcyc[3]     = '{default: 0};
  int   bad[3]      = '{default: 0};
  int   ndone[3]    = '{default: 0};
  int   done_at[3]  = '{default: 0};
  exp_t cur[3];

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!reset_n) begin
        in_frame[i] = 1'b0;
      end else begin
        if (!in_frame[i]) begin
          if (done_v[i] !== 1'b0) check($sformatf("done_idle[%0d]", i), {31'd0, done_v[i]}, 0);
          if (dout_v[i] === 1'b0) begin
            in_frame[i] = 1'b1;
            fcyc[i] = 0; bad[i] = 0; ndone[i] = 0; done_at[i] = -1;
            if (exp_q.size() == 0) begin
              have[i] = 1'b0;
              check($sformatf("unexpected_frame[%0d] queue", i), exp_q.size(), 1);
            end else begin
              have[i] = 1'b1;
              cur[i] = exp_q.pop_front();
              check($sformatf("frame_inst[%0d]", i), cur[i].inst, i);
              check($sformatf("start_cycle[%0d]", i), cyc, cur[i].acc_cyc + 1);
            end
          end
        end
        if (in_frame[i]) begin
          if (have[i] && dout_v[i] !== cur[i].bits[fcyc[i] / cpb[i]]) bad[i]++;
          if (done_v[i] === 1'b1) begin
            ndone[i]++;
            done_at[i] = fcyc[i];
          end
          if (fcyc[i] == nbits[i] * cpb[i] - 1) begin
            if (have[i]) begin
              check($sformatf("frame_bits[%0d] bad cycles", i), bad[i], 0);
              check($sformatf("done_pos[%0d]", i), done_at[i], fcyc[i]);
              check($sformatf("done_count[%0d]", i), ndone[i], 1);
            end
            frames_done++;
            in_frame[i] = 1'b0;
          end
          fcyc[i]++;
        end
      end
    end
  end

  initial begin
    set_in(0, 1'b0, 8'h00);
    set_in(1, 1'b0, 8'h00);
    set_in(2, 1'b0, 8'h00);
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset dout",     {31'd0, dout_v[0]}, 1);
    check("reset busy",     {31'd0, busy_v[0]}, 0);
    check("reset done",     {31'd0, done_v[0]}, 0);
    check("reset in_ready", {31'd0, if_a.in_ready}, 1);
    check("reset dout all", {29'd0, dout_v}, 7);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle line after release", {29'd0, dout_v}, 7);
    check("idle busy after release", {29'd0, busy_v}, 0);

    // Single byte: 0xA5 -> 0,1,0,1,0,0,1,0,1,1
    send(0, 8'hA5, {2'b11, 1'b1, 8'hA5, 1'b0}, 1'b0);
    repeat (14) @(negedge clk);

    // Back-to-back 0x00 then 0xFF, in_valid held across both.
    send(0, 8'h00, {2'b11, 1'b1, 8'h00, 1'b0}, 1'b1);
    send(0, 8'hFF, {2'b11, 1'b1, 8'hFF, 1'b0}, 1'b0);
    repeat (14) @(negedge clk);

    // Busy ignore: other data offered mid-frame must not change or add frames.
    send(0, 8'h3C, {2'b11, 1'b1, 8'h3C, 1'b0}, 1'b0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      set_in(0, (k % 2 == 0), 8'h99);
    end
    set_in(0, 1'b0, 8'h00);
    repeat (20) @(negedge clk);

    // Reset during DATA bit 3 (accept N, bit 3 occupies cycle N+5).
    send(0, 8'h5A, {2'b11, 1'b1, 8'h5A, 1'b0}, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    check("busy before reset", {31'd0, busy_v[0]}, 1);
    reset_n = 1'b0;
    #1;
    check("async reset dout",     {31'd0, dout_v[0]}, 1);
    check("async reset busy",     {31'd0, busy_v[0]}, 0);
    check("async reset in_ready", {31'd0, if_a.in_ready}, 1);
    repeat (2) @(negedge clk);
    exp_q.delete();
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    send(0, 8'hC3, {2'b11, 1'b1, 8'hC3, 1'b0}, 1'b0);
    repeat (14) @(negedge clk);

    // Even parity, 4 clocks/bit: 0x07 -> parity 1, 0x03 -> parity 0; 44-cycle frames.
    send(1, 8'h07, {1'b1, 1'b1, 1'b1, 8'h07, 1'b0}, 1'b0);
    repeat (50) @(negedge clk);
    send(1, 8'h03, {1'b1, 1'b1, 1'b0, 8'h03, 1'b0}, 1'b0);
    repeat (50) @(negedge clk);

    // Odd parity, two stop bits, back-to-back: 0x07 -> parity 0, 0x00 -> parity 1.
    send(2, 8'h07, {1'b1, 1'b1, 1'b0, 8'h07, 1'b0}, 1'b1);
    send(2, 8'h00, {1'b1, 1'b1, 1'b1, 8'h00, 1'b0}, 1'b0);
    repeat (30) @(negedge clk);

    check("expected queue drained", exp_q.size(), 0);
    check("completed frames", frames_done, 9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
